cvbs_sync_gen: RTL and testbench

Composite-video transmitter and the counterpart of the sync-detect receive path. It generates 312-line progressive PAL-style timing: hsync, broad vsync pulses and equalizing pulses. Luma is clamped and cookie-cut to the same level scheme the receiver recovers: 0 = sync tip, BLACKLEVEL = black, BLACKLEVEL+SPAN = white. The resulting level drives a 1-bit first-order sigma-delta DAC pin.

---
 rtl/cvbs_timing_pkg.sv | 43 ++++
 rtl/cvbs_sync_gen_if.sv | 15 +
 rtl/cvbs_sync_gen_sd_dac.sv | 33 +++
 rtl/cvbs_sync_gen.sv | 201 ++++++++++++++++++++
 tb/tb_cvbs_sync_gen.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cvbs_timing_pkg.sv
// Shared definitions for the composite-video sync generator.
//   - line_type_e : per-line pulse structure (broad / equalizing / blank / active)
//   - DEF_*       : default timing for a 24 MHz sample clock, 312-line progressive
//   - grey_lut()  : builds the 8-step grey-bar level table used by TEST_PATTERN_EN
package cvbs_timing_pkg;

    typedef enum logic [1:0] {
        LT_BROAD  = 2'd0,
        LT_EQ     = 2'd1,
        LT_BLANK  = 2'd2,
        LT_ACTIVE = 2'd3
    } line_type_e;

    localparam int unsigned DEF_RESOLUTION   = 6;
    localparam int unsigned DEF_BLACKLEVEL   = 8;
    localparam int unsigned DEF_SPAN         = 24;
    localparam int unsigned DEF_LINE_LEN     = 1536;
    localparam int unsigned DEF_HSYNC_LEN    = 113;
    localparam int unsigned DEF_EQ_LEN       = 56;
    localparam int unsigned DEF_BROAD_LEN    = 655;
    localparam int unsigned DEF_ACT_START    = 250;
    localparam int unsigned DEF_ACT_END      = 1495;
    localparam int unsigned DEF_LINES        = 312;
    localparam int unsigned DEF_FIRST_ACTIVE = 23;
    localparam int unsigned DEF_LAST_ACTIVE  = 309;

    // Grey bars: one step every BAR_STEP active clocks, saturating at bar 7.
    localparam int unsigned BAR_STEP = 156;
    localparam int unsigned BAR_LAST = 7;
    localparam int unsigned LUT_W    = 16;

    // Entry i = black + i*span/7, packed LUT_W bits per entry.
    function automatic logic [8*LUT_W-1:0] grey_lut(input int unsigned black,
                                                    input int unsigned span);
        logic [8*LUT_W-1:0] lut;
        lut = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            lut[i*LUT_W +: LUT_W] = LUT_W'(black + (i * span) / 7);
        end
        return lut;
    endfunction

endpackage

// File: rtl/cvbs_sync_gen_if.sv
// Pixel handshake between a pixel source and the sync generator.
//   luma        : pixel value, consumed in cycles where pix_req=1
//   pattern_sel : select internal grey bars (only with TEST_PATTERN_EN)
//   pix_req     : generator requests/consumes a pixel this cycle
// master = pixel source, slave = cvbs_sync_gen.
interface cvbs_sync_gen_if #(
    parameter int unsigned RESOLUTION = 6
);
    logic [RESOLUTION-1:0] luma;
    logic                  pattern_sel;
    logic                  pix_req;

    modport master (output luma, output pattern_sel, input pix_req);
    modport slave  (input luma, input pattern_sel, output pix_req);
endinterface

// File: rtl/cvbs_sync_gen_sd_dac.sv
// First-order sigma-delta DAC: ones density of dac_out over 2^RESOLUTION
// clocks equals sample/2^RESOLUTION.
//   clk, reset_n : clock, asynchronous active-low reset
//   sample       : level to convert
//   dac_out      : registered 1-bit stream (accumulator carry)
module sd_dac #(
    parameter int unsigned RESOLUTION = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [RESOLUTION-1:0] sample,
    output logic                  dac_out
);

    logic [RESOLUTION:0] acc_q;
    logic [RESOLUTION:0] acc_d;

    // Carry is dropped every cycle; only the low bits accumulate.
    always_comb begin
        acc_d = {1'b0, acc_q[RESOLUTION-1:0]} + {1'b0, sample};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign dac_out = acc_q[RESOLUTION];

endmodule

// File: rtl/cvbs_sync_gen.sv
// 312-line progressive PAL-style composite video transmitter.
// Generates hsync, broad vsync and equalizing pulses, cookie-cuts luma into
// 0 = sync tip, BLACKLEVEL = black, BLACKLEVEL+SPAN = white, and drives a
// 1-bit sigma-delta DAC.
//   clk, reset_n : sample clock, asynchronous active-low reset
//   pix          : pixel handshake (luma, pattern_sel in; pix_req out)
//   hsync_n      : line sync, active low
//   vsync_n      : low for the broad lines 0..2
//   csync_n      : composite sync tip, active low
//   porch        : back porch on non-vsync lines
//   sample       : registered output level
//   dac_out      : sigma-delta bitstream of sample
// Optional build macro TEST_PATTERN_EN: pattern_sel=1 replaces luma with
// 8 grey bars.
module cvbs_sync_gen
    import cvbs_timing_pkg::*;
#(
    parameter int unsigned RESOLUTION   = DEF_RESOLUTION,
    parameter int unsigned BLACKLEVEL   = DEF_BLACKLEVEL,
    parameter int unsigned SPAN         = DEF_SPAN,
    parameter int unsigned LINE_LEN     = DEF_LINE_LEN,
    parameter int unsigned HSYNC_LEN    = DEF_HSYNC_LEN,
    parameter int unsigned EQ_LEN       = DEF_EQ_LEN,
    parameter int unsigned BROAD_LEN    = DEF_BROAD_LEN,
    parameter int unsigned ACT_START    = DEF_ACT_START,
    parameter int unsigned ACT_END      = DEF_ACT_END,
    parameter int unsigned LINES        = DEF_LINES,
    parameter int unsigned FIRST_ACTIVE = DEF_FIRST_ACTIVE,
    parameter int unsigned LAST_ACTIVE  = DEF_LAST_ACTIVE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cvbs_sync_gen_if.slave        pix,
    output logic                  hsync_n,
    output logic                  vsync_n,
    output logic                  csync_n,
    output logic                  porch,
    output logic [RESOLUTION-1:0] sample,
    output logic                  dac_out
);

    localparam int unsigned HW = $clog2(LINE_LEN);
    localparam int unsigned VW = $clog2(LINES);
    localparam int unsigned RW = RESOLUTION + 1;

    localparam logic [HW-1:0] H_LAST  = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_HALF  = HW'(LINE_LEN / 2);
    localparam logic [HW-1:0] H_HS    = HW'(HSYNC_LEN);
    localparam logic [HW-1:0] H_EQ    = HW'(EQ_LEN);
    localparam logic [HW-1:0] H_BR    = HW'(BROAD_LEN);
    localparam logic [HW-1:0] H_AS    = HW'(ACT_START);
    localparam logic [HW-1:0] H_AE    = HW'(ACT_END);
    localparam logic [HW-1:0] H_ONE   = HW'(1);

    localparam logic [VW-1:0] V_LAST  = VW'(LINES - 1);
    localparam logic [VW-1:0] V_EQ_HI = VW'(LINES - 2);
    localparam logic [VW-1:0] V_BR_E  = VW'(3);
    localparam logic [VW-1:0] V_EQ_E  = VW'(5);
    localparam logic [VW-1:0] V_FA    = VW'(FIRST_ACTIVE);
    localparam logic [VW-1:0] V_LA    = VW'(LAST_ACTIVE);
    localparam logic [VW-1:0] V_ONE   = VW'(1);

    localparam logic [RW-1:0] LVL_LO  = RW'(BLACKLEVEL);
    localparam logic [RW-1:0] LVL_HI  = RW'(BLACKLEVEL + SPAN);
    localparam logic [RESOLUTION-1:0] LVL_BLACK = RESOLUTION'(BLACKLEVEL);

    function automatic line_type_e classify(input logic [VW-1:0] v);
        if (v < V_BR_E)       return LT_BROAD;
        else if (v < V_EQ_E)  return LT_EQ;
        else if (v >= V_EQ_HI) return LT_EQ;
        else if (v < V_FA)    return LT_BLANK;
        else if (v <= V_LA)   return LT_ACTIVE;
        else                  return LT_BLANK;
    endfunction

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [VW-1:0] vcount_next;
    line_type_e    lt_q, lt_d;

    logic [HW-1:0] h_half;
    logic          h_wrap;
    logic          tip;
    logic          pix_req_w;
    logic [RESOLUTION-1:0] luma_src;
    logic [RW-1:0] luma_ext;
    logic [RW-1:0] luma_clamped;

    logic [RESOLUTION-1:0] sample_q, sample_d;
    logic hsync_n_q, hsync_n_d;
    logic vsync_n_q, vsync_n_d;
    logic csync_n_q, csync_n_d;
    logic porch_q, porch_d;

`ifdef TEST_PATTERN_EN
    localparam logic [8*LUT_W-1:0] GREY_LUT = grey_lut(BLACKLEVEL, SPAN);
    localparam logic [7:0] BAR_CNT_LAST = 8'(BAR_STEP - 1);
    localparam logic [2:0] BAR_MAX      = 3'(BAR_LAST);

    logic [7:0] bar_cnt_q;
    logic [2:0] bar_q;

    // Bar index restarts every active span; advancing a counter avoids a divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bar_cnt_q <= '0;
            bar_q     <= '0;
        end else if (!pix_req_w) begin
            bar_cnt_q <= '0;
            bar_q     <= '0;
        end else if (bar_cnt_q == BAR_CNT_LAST) begin
            bar_cnt_q <= '0;
            if (bar_q != BAR_MAX) begin
                bar_q <= bar_q + 3'd1;
            end
        end else begin
            bar_cnt_q <= bar_cnt_q + 8'd1;
        end
    end

    always_comb begin
        luma_src = pix.pattern_sel ? GREY_LUT[int'(bar_q)*LUT_W +: RESOLUTION] : pix.luma;
    end
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pix.pattern_sel;

    always_comb begin
        luma_src = pix.luma;
    end
`endif

    always_comb begin
        h_wrap      = (hcount_q == H_LAST);
        vcount_next = (vcount_q == V_LAST) ? '0 : vcount_q + V_ONE;
        hcount_d    = h_wrap ? '0 : hcount_q + H_ONE;
        vcount_d    = h_wrap ? vcount_next : vcount_q;
        lt_d        = h_wrap ? classify(vcount_next) : lt_q;

        h_half = (hcount_q >= H_HALF) ? hcount_q - H_HALF : hcount_q;

        case (lt_q)
            LT_BROAD: tip = (h_half < H_BR);
            LT_EQ:    tip = (h_half < H_EQ);
            default:  tip = (hcount_q < H_HS);
        endcase

        pix_req_w = (lt_q == LT_ACTIVE) && (hcount_q >= H_AS) && (hcount_q <= H_AE);

        luma_ext = {1'b0, luma_src};
        if (luma_ext < LVL_LO)      luma_clamped = LVL_LO;
        else if (luma_ext > LVL_HI) luma_clamped = LVL_HI;
        else                        luma_clamped = luma_ext;

        if (tip)             sample_d = '0;
        else if (!pix_req_w) sample_d = LVL_BLACK;
        else                 sample_d = luma_clamped[RESOLUTION-1:0];

        hsync_n_d = !(hcount_q < H_HS);
        vsync_n_d = (lt_q != LT_BROAD);
        csync_n_d = !tip;
        porch_d   = (lt_q != LT_BROAD) && (hcount_q >= H_HS) && (hcount_q < H_AS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q  <= '0;
            vcount_q  <= '0;
            lt_q      <= LT_BROAD;
            sample_q  <= LVL_BLACK;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            csync_n_q <= 1'b1;
            porch_q   <= 1'b0;
        end else begin
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            lt_q      <= lt_d;
            sample_q  <= sample_d;
            hsync_n_q <= hsync_n_d;
            vsync_n_q <= vsync_n_d;
            csync_n_q <= csync_n_d;
            porch_q   <= porch_d;
        end
    end

    sd_dac #(.RESOLUTION(RESOLUTION)) u_dac (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (sample_q),
        .dac_out (dac_out)
    );

    assign pix.pix_req = pix_req_w;
    assign sample      = sample_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign csync_n     = csync_n_q;
    assign porch       = porch_q;

endmodule

// File: tb/tb_cvbs_sync_gen.sv
// Bench for cvbs_sync_gen: a default-timing instance (A) and a short-line
// instance (B) small enough to run through two full frames.
module tb_cvbs_sync_gen;

    localparam int RES  = 6;
    localparam int BL   = 8;
    localparam int SPAN = 24;

    typedef struct {
        int L, hs, eq, br, act_s, act_e, lines, fa, la;
    } tp_t;

    typedef struct packed {
        logic       req;
        logic [5:0] smp;
        logic       hs, vs, cs, po;
    } exp_t;

    localparam tp_t TP_A = '{1536, 113, 56, 655, 250, 1495, 312, 23, 309};
    localparam tp_t TP_B = '{64, 5, 2, 27, 10, 60, 312, 23, 309};
    localparam int FRAME_B = 312 * 64;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    cvbs_sync_gen_if #(.RESOLUTION(RES)) if_a ();
    cvbs_sync_gen_if #(.RESOLUTION(RES)) if_b ();

    logic hs_a, vs_a, cs_a, po_a, dac_a;
    logic hs_b, vs_b, cs_b, po_b, dac_b;
    logic [5:0] smp_a, smp_b;

    cvbs_sync_gen dut_a (
        .clk(clk), .reset_n(rst_a), .pix(if_a),
        .hsync_n(hs_a), .vsync_n(vs_a), .csync_n(cs_a), .porch(po_a),
        .sample(smp_a), .dac_out(dac_a)
    );

    cvbs_sync_gen #(
        .LINE_LEN(64), .HSYNC_LEN(5), .EQ_LEN(2), .BROAD_LEN(27),
        .ACT_START(10), .ACT_END(60)
    ) dut_b (
        .clk(clk), .reset_n(rst_b), .pix(if_b),
        .hsync_n(hs_b), .vsync_n(vs_b), .csync_n(cs_b), .porch(po_b),
        .sample(smp_b), .dac_out(dac_b)
    );

    int errors = 0;
    int checks = 0;
    int n_a, n_b;
    bit act_a, act_b, first_run;
    exp_t qa[$];
    exp_t qb[$];
    int cnt_l0_tip, cs_l1, vs_l1, cs_l3, req_l23, first_req, dac_ones;

    function automatic exp_t model(input tp_t p, input int n, input int luma);
        int line, h, hh, lv;
        bit broad, eq, act, tip;
        exp_t e;
        line  = (n / p.L) % p.lines;
        h     = n % p.L;
        hh    = h % (p.L / 2);
        broad = (line < 3);
        eq    = (line == 3) || (line == 4) || (line >= p.lines - 2);
        act   = !broad && !eq && (line >= p.fa) && (line <= p.la);
        if (broad)   tip = (hh < p.br);
        else if (eq) tip = (hh < p.eq);
        else         tip = (h < p.hs);
        e.req = act && (h >= p.act_s) && (h <= p.act_e);
        lv = (luma < BL) ? BL : ((luma > BL + SPAN) ? BL + SPAN : luma);
        e.smp = tip ? 6'd0 : (!e.req ? 6'(BL) : 6'(lv));
        e.hs = !(h < p.hs);
        e.vs = !broad;
        e.cs = !tip;
        e.po = !broad && (h >= p.hs) && (h < p.act_s);
        return e;
    endfunction

    function automatic int luma_for_a(input int n);
        int line, h;
        line = n / 1536;
        h    = n % 1536;
        if (line != 23) return 31;
        if (h < 400)  return 31;
        if (h < 600)  return 16;
        if (h < 800)  return 3;
        if (h < 1000) return 40;
        if (h < 1200) return 20;
        return 31;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag, input logic [5:0] s, input logic h,
                             input logic v, input logic c, input logic p,
                             input logic r, input logic d);
        chk({tag, "_sample"}, s, BL);
        chk({tag, "_hsync"}, h, 1);
        chk({tag, "_vsync"}, v, 1);
        chk({tag, "_csync"}, c, 1);
        chk({tag, "_porch"}, p, 0);
        chk({tag, "_pixreq"}, r, 0);
        chk({tag, "_dac"}, d, 0);
    endtask

    // One clock: drive + push expectations at negedge, pop + compare after posedge.
    // kill_a asserts A's reset mid-cycle and checks the outputs immediately.
    task automatic step(input bit kill_a);
        exp_t e;
        int la, lb, line, h;
        @(negedge clk);
        if (kill_a) begin
            rst_a = 1'b0;
            act_a = 1'b0;
            first_run = 1'b0;
            #1;
            chk_reset("midrst_a", smp_a, hs_a, vs_a, cs_a, po_a, if_a.pix_req, dac_a);
        end
        if (act_a) begin
            la = luma_for_a(n_a);
            if_a.luma = 6'(la);
            e = model(TP_A, n_a, la);
            qa.push_back(e);
            chk("pixreq_a", if_a.pix_req, e.req);
            if (first_run && (n_a / 1536 == 23) && if_a.pix_req === 1'b1) begin
                req_l23++;
                if (first_req < 0) first_req = n_a;
            end
        end
        if (act_b) begin
            lb = int'($urandom_range(0, 63));
            if_b.luma = 6'(lb);
            e = model(TP_B, n_b, lb);
            qb.push_back(e);
            chk("pixreq_b", if_b.pix_req, e.req);
        end
        @(posedge clk);
        #1;
        if (act_a) begin
            e = qa.pop_front();
            chk("out_a", {smp_a, hs_a, vs_a, cs_a, po_a}, {e.smp, e.hs, e.vs, e.cs, e.po});
            if (first_run) begin
                line = n_a / 1536;
                h    = n_a % 1536;
                if (line == 0 && h < 113 && smp_a === 6'd0 && cs_a === 1'b0) cnt_l0_tip++;
                if (line == 1 && cs_a === 1'b0) cs_l1++;
                if (line == 1 && vs_a === 1'b0) vs_l1++;
                if (line == 3 && cs_a === 1'b0) cs_l3++;
                if (line == 3 && h == 768)      chk("l3_eq2_start", cs_a, 0);
                if (line == 3 && h == 824)      chk("l3_eq2_end", cs_a, 1);
                if (line == 23 && h == 250)     chk("first_pixel", smp_a, 31);
                if (line == 23 && h == 650)     chk("clamp_low", smp_a, 8);
                if (line == 23 && h == 850)     chk("clamp_high", smp_a, 32);
                if (line == 23 && h == 1050)    chk("clamp_mid", smp_a, 20);
                if (line == 23 && h >= 450 && h < 514 && dac_a === 1'b1) dac_ones++;
            end
            n_a++;
        end
        if (act_b) begin
            e = qb.pop_front();
            chk("out_b", {smp_b, hs_b, vs_b, cs_b, po_b}, {e.smp, e.hs, e.vs, e.cs, e.po});
            if (n_b == FRAME_B - 1) begin
                chk("b_l311_vsync", vs_b, 1);
                chk("b_l311_csync", cs_b, 1);
            end
            if (n_b == FRAME_B) begin
                chk("b_wrap_vsync", vs_b, 0);
                chk("b_wrap_csync", cs_b, 0);
                chk("b_wrap_hsync", hs_b, 0);
            end
            n_b++;
        end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        act_a = 1'b0;
        act_b = 1'b0;
        first_run = 1'b0;
        if_a.luma = 6'd31;
        if_a.pattern_sel = 1'b0;
        if_b.luma = 6'd0;
        if_b.pattern_sel = 1'b0;
        n_a = 0;
        n_b = 0;
        cnt_l0_tip = 0; cs_l1 = 0; vs_l1 = 0; cs_l3 = 0;
        req_l23 = 0; first_req = -1; dac_ones = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst_a", smp_a, hs_a, vs_a, cs_a, po_a, if_a.pix_req, dac_a);
        chk_reset("rst_b", smp_b, hs_b, vs_b, cs_b, po_b, if_b.pix_req, dac_b);

        rst_a = 1'b1;
        rst_b = 1'b1;
        act_a = 1'b1;
        act_b = 1'b1;
        first_run = 1'b1;

        // A runs to line 24, hcount 700; B runs alongside.
        while (n_a < 24 * 1536 + 700) step(1'b0);

        chk("l0_tip_len", cnt_l0_tip, 113);
        chk("l1_csync_low", cs_l1, 1310);
        chk("l1_vsync_low", vs_l1, 1536);
        chk("l3_csync_low", cs_l3, 112);
        chk("l23_pixreq_cnt", req_l23, 1246);
        chk("first_pixreq_at", first_req, 23 * 1536 + 250);
        chk("dac_density16", dac_ones, 16);

        // Mid-line reset of A, held for two more clocks.
        step(1'b1);
        step(1'b0);
        step(1'b0);
        rst_a = 1'b1;
        act_a = 1'b1;
        n_a = 0;
        step(1'b0);
        chk("post_rst_csync", cs_a, 0);
        chk("post_rst_vsync", vs_a, 0);

        // B through its second frame boundary.
        while (n_b < 2 * FRAME_B + 8) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
